// File: rtl/booth_mul_sched.sv
// Sequential radix-2 Booth multiplier shared by two requesters under round-robin arbitration.
// One Booth step per clock; the product is tagged with the ID of the issuing requester.
module booth_mul_sched #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] LastStep = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH:0]       mcand_q, mcand_d;
  logic [2*WIDTH+1:0]   p_q, p_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 id_q, id_d;
  logic                 last_grant_q, last_grant_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0]   rsp_result_q, rsp_result_d;

  logic                 grant;
  logic                 accept;
  logic [WIDTH-1:0]     sel_a, sel_b;
  logic [WIDTH:0]       acc, acc_sum;
  logic [2*WIDTH+1:0]   p_step;

  // Both valid: alternate away from the last winner; otherwise the lone valid requester wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
  end

  assign req0_ready = (state_q == StIdle) && req0_valid && !grant;
  assign req1_ready = (state_q == StIdle) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign sel_a      = grant ? req1_a : req0_a;
  assign sel_b      = grant ? req1_b : req0_b;

  // Accumulator is WIDTH+1 bits wide so subtracting the most-negative multiplicand cannot overflow.
  always_comb begin
    acc = p_q[2*WIDTH+1:WIDTH+1];
    case (p_q[1:0])
      2'b01:   acc_sum = acc + mcand_q;
      2'b10:   acc_sum = acc - mcand_q;
      default: acc_sum = acc;
    endcase
    p_step = {acc_sum[WIDTH], acc_sum, p_q[WIDTH:1]};
  end

  always_comb begin
    state_d      = state_q;
    mcand_d      = mcand_q;
    p_d          = p_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mcand_d      = {sel_a[WIDTH-1], sel_a};
          p_d          = {{(WIDTH+1){1'b0}}, sel_b, 1'b0};
          id_d         = grant;
          last_grant_d = grant;
          cnt_d        = '0;
          state_d      = StRun;
        end
      end
      StRun: begin
        p_d   = p_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastStep) begin
          rsp_result_d = p_step[2*WIDTH:1];
          rsp_valid_d  = 1'b1;
          state_d      = StDone;
        end
      end
      StDone: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      mcand_q      <= '0;
      p_q          <= '0;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      mcand_q      <= mcand_d;
      p_q          <= p_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed self-checking bench for booth_mul_sched: products, latency, arbitration,
// backpressure, asynchronous reset, plus a randomised run against a signed reference product.
module tb_booth_mul_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [63:0] rsp_result;

  int errors = 0;
  int checks = 0;

  booth_mul_sched #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea, eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  // Issues one operation on requester id and checks acceptance, latency, product and tag.
  task automatic do_op(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int stall, input int max_wait,
                       input string tag);
    int n;
    int edges;
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    rsp_ready = (stall == 0);
    n = 0;
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_accept"}, 64'(n <= max_wait), 64'd1);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    // Garble the operands after acceptance; the engine must not look at them again.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
    while (!rsp_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 64'(edges), 64'd33);
    chk({tag, "_result"}, rsp_result, exp);
    chk({tag, "_id"}, 64'(rsp_id), 64'(id));
    if (stall > 0) begin
      repeat (stall) @(negedge clk);
      chk({tag, "_stall_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_stall_result"}, rsp_result, exp);
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_released"}, 64'({rsp_valid, busy}), 64'd0);
  endtask

  initial begin
    int ops;
    int n;
    logic exp_id;
    logic [31:0] ra, rb;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rsp_result[61:0], rsp_valid, rsp_id}, 64'd0);
    chk("reset_result_hi", 64'(rsp_result[63:62]), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0, 0, "r0_7x-3");
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 0, "minxmin");
    do_op(1'b0, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000, 0, 0, "minx1");
    do_op(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 0, 0, "maxxmax");
    do_op(1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 64'd30, 2, 0, "r1_-5x-6");

    // Round-robin from a fresh reset: both requesters valid, expect 0,1,0,1.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd7;         req0_b = 32'hFFFF_FFFD;
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFB; req1_b = 32'hFFFF_FFFA;
    rsp_ready = 1'b1;
    ops = 0;
    n = 0;
    while (ops < 4 && n < 200) begin
      @(negedge clk);
      n++;
      chk("rr_one_ready", 64'(req0_ready && req1_ready), 64'd0);
      if (rsp_valid) begin
        exp_id = ops[0];
        chk("rr_id", 64'(rsp_id), 64'(exp_id));
        chk("rr_result", rsp_result, exp_id ? 64'd30 : 64'hFFFF_FFFF_FFFF_FFEB);
        ops++;
      end
    end
    chk("rr_ops", 64'(ops), 64'd4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Backpressure in DONE with req1 pending.
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'hFFFF_FFFE;
    rsp_ready = 1'b0;
    #1;
    chk("bp_accept", 64'(req0_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFB; req1_b = 32'hFFFF_FFFA;
    n = 0;
    while (!rsp_valid && n < 100) begin
      chk("bp_run_r1_blocked", 64'(req1_ready), 64'd0);
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_result", rsp_result, 64'hFFFF_FFFF_FFFF_FF38);
      chk("bp_id", 64'(rsp_id), 64'd0);
      chk("bp_r1_blocked", 64'(req1_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_released", 64'(rsp_valid), 64'd0);
    chk("bp_r1_ready_after", 64'(req1_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_r1_result", rsp_result, 64'd30);
    chk("bp_r1_id", 64'(rsp_id), 64'd1);
    @(negedge clk);

    // Reset mid-RUN at counter 10.
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("run_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("run_reset_async", 64'({rsp_valid, busy}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-DONE must drop rsp_valid at once.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_valid_before", 64'(rsp_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("done_reset_async", 64'({rsp_valid, busy}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_rsp", 64'(rsp_valid), 64'd0);
    end
    do_op(1'b0, 32'd3, 32'd4, 64'd12, 0, 0, "post_reset_3x4");

    // Randomised operations with issue gaps and response stalls.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op(1'($urandom_range(0, 1)), ra, rb, ref_mul(ra, rb), $urandom_range(0, 3), 100,
            "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_mul_sched.md
Name: booth_mul_sched

Overview:
- Sequential radix-2 Booth multiply engine, shared between two ALU requesters under round-robin arbitration.
- Performs one Booth step per clock, instead of the fully unrolled combinational multiplier.
- Sits between the ALU issue ports and the result writeback path.
- Produces the exact signed 2*WIDTH-bit product, tagged with the ID of the requester that issued the operands.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has operands.
- req0_ready  output  1  requester 0 operands accepted this cycle.
- req0_a  input  WIDTH  requester 0 multiplicand, two's complement.
- req0_b  input  WIDTH  requester 0 multiplier, two's complement.
- req1_valid  input  1  requester 1 has operands.
- req1_ready  output  1  requester 1 operands accepted this cycle.
- req1_a  input  WIDTH  requester 1 multiplicand.
- req1_b  input  WIDTH  requester 1 multiplier.
- rsp_valid  output  1  product available.
- rsp_ready  input  1  consumer accepts product.
- rsp_id  output  1  requester that issued this product (0 or 1).
- rsp_result  output  2*WIDTH  signed product.
- busy  output  1  high in RUN and DONE states.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; rsp_valid=0, rsp_id=0, rsp_result=0, busy=0.
  - Counter=0; last_grant=1, so requester 0 has priority first.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE, arbitration (combinational):
  - One valid requester: it is granted.
  - Both valid: grant the requester not equal to last_grant.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high per cycle. Ready may depend on valid.
- Acceptance edge (reqN_valid && reqN_ready):
  - Capture a into the multiplicand register (WIDTH+1 bits, sign-extended).
  - Load P = {(WIDTH+1) zeros, b, 1'b0}.
  - Set id=N, last_grant=N, counter=0; go to RUN.
  - Operand inputs are ignored after acceptance.
- RUN, one Booth step per edge:
  - Inspect P[1:0]: 01 adds the multiplicand to the upper WIDTH+1 bits; 10 subtracts it; 00/11 leaves them unchanged.
  - Then arithmetic right shift of P by 1. Counter increments.
  - The accumulator field is WIDTH+1 bits, so the most-negative multiplicand (-2^(WIDTH-1)) never overflows.
  - On the edge completing step WIDTH: rsp_result <= P bits [2*WIDTH:1], rsp_valid <= 1; go to DONE.
- Latency: rsp_valid rises exactly WIDTH+1 rising edges after the acceptance edge (1 load + WIDTH steps), i.e. the 33rd edge for WIDTH=32.
- DONE:
  - rsp_valid=1; rsp_result and rsp_id held stable while rsp_ready=0, for unbounded backpressure.
  - On rsp_valid && rsp_ready: rsp_valid<=0, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake. Minimum issue-to-issue spacing is WIDTH+2 cycles.
- Requests arriving during RUN/DONE see ready=0 and must hold valid; they are not lost and not queued internally.
- rsp_result is registered and retains its last value after the handshake until the next completion.
- Reset asserted mid-RUN or mid-DONE: the operation is abandoned, with no response and no partial result visible. The requester must reissue.

Test Plan:
- After reset, req0 only: a=7, b=-3 -> accepted on first edge; rsp_valid on 33rd edge after acceptance with rsp_result=0xFFFFFFFFFFFFFFEB, rsp_id=0.
- a=0x80000000, b=0x80000000 -> rsp_result=0x4000000000000000. Also a=0x80000000, b=1 -> 0xFFFFFFFF80000000; a=0x7FFFFFFF, b=0x7FFFFFFF -> 0x3FFFFFFF00000001.
- Both requesters valid continuously, rsp_ready=1: grants alternate 0,1,0,1 for four operations. rsp_id alternates to match; each product is correct (e.g. req1 a=-5, b=-6 -> 30). Only one ready is high in any cycle.
- Hold rsp_ready=0 for 10 cycles in DONE -> rsp_valid, rsp_result and rsp_id remain constant. Pending req1_valid sees ready=0 throughout; req1 is accepted only after the response handshake.
- Assert rst at counter=10 during RUN -> rsp_valid and busy drop immediately (asynchronously). After release, the next req0 with a=3, b=4 returns 12 with no stale response.
- Randomised 1000 operations, random valid and rsp_ready stalls -> every result matches the signed reference product. Per-requester ordering is preserved; no request is dropped or duplicated.
